wb_cmd_master: RTL

Parametrised Wishbone B4 bus master for the simulation harness and on-chip debug paths. It replaces direct wire-driving of the `wishbone_*` signals into the USB device core with a queued command/response engine. Commands carry address, data, byte-select, direction and burst-continuation. The block issues classic and incrementing-burst cycles, applies a per-beat timeout, and returns exactly one response per command through a response FIFO.

---
 rtl/wb_cmd_master.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// Queued Wishbone B4 master: commands enter a FIFO, the FSM turns each one
// into a classic or incrementing-burst beat, and exactly one response per
// command comes back through a response FIFO.
module wb_cmd_master #(
  parameter int ADR_WIDTH = 30,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk48,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADR_WIDTH-1:0] cmd_adr,
  input  logic [DAT_WIDTH-1:0] cmd_dat,
  input  logic [SEL_WIDTH-1:0] cmd_sel,
  input  logic                 cmd_last,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DAT_WIDTH-1:0] rsp_dat,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [ADR_WIDTH-1:0] wishbone_adr,
  output logic [DAT_WIDTH-1:0] wishbone_dat_w,
  output logic [SEL_WIDTH-1:0] wishbone_sel,
  output logic                 wishbone_we,
  output logic                 wishbone_cyc,
  output logic                 wishbone_stb,
  output logic [2:0]           wishbone_cti,
  output logic [1:0]           wishbone_bte,
  input  logic [DAT_WIDTH-1:0] wishbone_dat_r,
  input  logic                 wishbone_ack,
  input  logic                 wishbone_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat;
    logic [SEL_WIDTH-1:0] sel;
    logic                 last;
  } cmd_t;

  typedef struct packed {
    logic [DAT_WIDTH-1:0] dat;
    logic                 err;
    logic                 timeout;
  } rsp_t;

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_GAP, S_FLUSH} state_t;

  cmd_t          cmd_mem [DEPTH];
  rsp_t          rsp_mem [DEPTH];
  cmd_t          cmd_in, head;
  rsp_t          rsp_in, rsp_head;
  logic [PW-1:0] cmd_wr_ptr, cmd_rd_ptr, cmd_wr_vis, cmd_count_vis;
  logic [PW-1:0] rsp_wr_ptr, rsp_rd_ptr, rsp_count;
  logic          cmd_full, cmd_push, cmd_pop, cmd_avail, cmd_next_avail;
  logic          rsp_full, rsp_push, rsp_pop, rsp_space_after;
  logic          ready_q, in_burst, burst_d, to_hit;
  logic [TW-1:0] to_cnt, to_cnt_d;
  state_t        state, state_d;

  // ---------------- command FIFO ----------------
  assign cmd_in   = cmd_t'{cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_last};
  assign cmd_full = (cmd_wr_ptr[AW] != cmd_rd_ptr[AW]) &&
                    (cmd_wr_ptr[AW-1:0] == cmd_rd_ptr[AW-1:0]);
  assign cmd_ready = ready_q & ~cmd_full;
  assign cmd_push  = cmd_valid & cmd_ready;
  assign head      = cmd_mem[cmd_rd_ptr[AW-1:0]];
  // The FSM sees writes one cycle late through cmd_wr_vis.
  assign cmd_count_vis  = cmd_wr_vis - cmd_rd_ptr;
  assign cmd_avail      = (cmd_count_vis != '0);
  assign cmd_next_avail = (cmd_count_vis > PW'(1));

  // Hold off cmd_ready until the first clock after reset release.
  // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Command storage write port.
  // NOTE: storage arrays have no reset; empty/full pointers make stale entries invisible.
  always_ff @(posedge clk48) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr[AW-1:0]] <= cmd_in;
  end

  // Command FIFO pointers plus the delayed write pointer seen by the FSM.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_wr_vis <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PW'(1);
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
      cmd_wr_vis <= cmd_wr_ptr;
    end
  end

  // ---------------- response FIFO ----------------
  assign rsp_count = rsp_wr_ptr - rsp_rd_ptr;
  assign rsp_full  = (rsp_wr_ptr[AW] != rsp_rd_ptr[AW]) &&
                     (rsp_wr_ptr[AW-1:0] == rsp_rd_ptr[AW-1:0]);
  assign rsp_valid = (rsp_count != '0);
  assign rsp_pop   = rsp_valid & rsp_ready;
  // A slot remains after this cycle's push (counting a same-cycle pop).
  assign rsp_space_after = (rsp_count - PW'(rsp_pop)) < PW'(DEPTH - 1);
  assign rsp_head    = rsp_mem[rsp_rd_ptr[AW-1:0]];
  assign rsp_dat     = rsp_valid ? rsp_head.dat : '0;
  assign rsp_err     = rsp_valid & rsp_head.err;
  assign rsp_timeout = rsp_valid & rsp_head.timeout;

  // Response storage write port.
  always_ff @(posedge clk48) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr[AW-1:0]] <= rsp_in;
  end

  // Response FIFO pointers.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + PW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + PW'(1);
    end
  end

  // ---------------- bus FSM ----------------
  assign to_hit = (to_cnt == TW'(TIMEOUT - 1)) & ~wishbone_ack & ~wishbone_err;

  // State, burst flag and per-beat timeout counter registers.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      in_burst <= 1'b0;
      to_cnt   <= '0;
    end else begin
      state    <= state_d;
      in_burst <= burst_d;
      to_cnt   <= to_cnt_d;
    end
  end

  // Next state, FIFO pops/pushes and response contents.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state;
    burst_d  = in_burst;
    to_cnt_d = '0;
    cmd_pop  = 1'b0;
    rsp_push = 1'b0;
    rsp_in   = '0;
    case (state)
      S_IDLE, S_GAP: begin
        if (cmd_avail && !rsp_full) state_d = S_BEAT;
      end
      S_BEAT: begin
        if (wishbone_ack || wishbone_err || to_hit) begin
          cmd_pop        = 1'b1;
          rsp_push       = 1'b1;
          rsp_in.err     = wishbone_err | to_hit;
          rsp_in.timeout = to_hit;
          rsp_in.dat     = (!wishbone_err && !to_hit && !head.we) ? wishbone_dat_r : '0;
          if (head.last) begin
            state_d = S_IDLE;
            burst_d = 1'b0;
          end else if (wishbone_err || to_hit) begin
            state_d = S_FLUSH;
            burst_d = 1'b0;
          end else begin
            burst_d = 1'b1;
            state_d = (cmd_next_avail && rsp_space_after) ? S_BEAT : S_GAP;
          end
        end else begin
          to_cnt_d = to_cnt + TW'(1);
        end
      end
      S_FLUSH: begin
        if (cmd_avail && !rsp_full) begin
          cmd_pop    = 1'b1;
          rsp_push   = 1'b1;
          rsp_in.err = 1'b1;
          if (head.last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset drops cyc/stb at once.
  assign wishbone_cyc   = (state == S_BEAT) || (state == S_GAP);
  assign wishbone_stb   = (state == S_BEAT);
  assign wishbone_adr   = wishbone_stb ? head.adr : '0;
  assign wishbone_dat_w = wishbone_stb ? head.dat : '0;
  assign wishbone_sel   = wishbone_stb ? head.sel : '0;
  assign wishbone_we    = wishbone_stb & head.we;
  assign wishbone_cti   = !wishbone_stb ? 3'b000 :
                          !head.last    ? 3'b010 :
                          in_burst      ? 3'b111 : 3'b000;
  assign wishbone_bte   = 2'b00;

endmodule
